// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit for the E stage: HI/LO registers, mthi/mtlo,
// and a busy flag that stays high for exactly MULT_CYCLES / DIV_CYCLES cycles.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic [2:0] {
    OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
  } mdop_e;
  typedef enum logic {IDLE, RUN} state_e;

  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  state_e        state_q;
  mdop_e         op_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   a_q, b_q, hi_q, lo_q;
  logic          busy_q;

  // Result is formed from the latched operands and written on the last RUN edge.
  logic [63:0] prod_s, prod_u;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, dsr, uq, ur;
  logic [31:0] hi_d, lo_d;
  logic        we_d;

  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    // Signed divide done on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
    neg_a  = (op_q == OP_DIV) && a_q[31];
    neg_b  = (op_q == OP_DIV) && b_q[31];
    mag_a  = neg_a ? (~a_q + 32'd1) : a_q;
    mag_b  = neg_b ? (~b_q + 32'd1) : b_q;
    dsr    = (mag_b == 32'd0) ? 32'd1 : mag_b;
    uq     = mag_a / dsr;
    ur     = mag_a % dsr;
    hi_d   = hi_q;
    lo_d   = lo_q;
    we_d   = 1'b0;
    case (op_q)
      OP_MULT:  begin {hi_d, lo_d} = prod_s; we_d = 1'b1; end
      OP_MULTU: begin {hi_d, lo_d} = prod_u; we_d = 1'b1; end
      OP_DIV, OP_DIVU: begin
        lo_d = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
        hi_d = neg_a ? (~ur + 32'd1) : ur;
        we_d = (b_q != 32'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_NONE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          case (mdop_e'(MDop))
            OP_MULT, OP_MULTU: begin
              a_q     <= A;
              b_q     <= B;
              op_q    <= mdop_e'(MDop);
              cnt_q   <= CW'(MULT_CYCLES);
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
            OP_DIV, OP_DIVU: begin
              a_q     <= A;
              b_q     <= B;
              op_q    <= mdop_e'(MDop);
              cnt_q   <= CW'(DIV_CYCLES);
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
            OP_MTHI: hi_q <= A;
            OP_MTLO: lo_q <= A;
            default: ;
          endcase
        end
        RUN: begin
          if (cnt_q == CW'(1)) begin
            if (we_d) begin
              hi_q <= hi_d;
              lo_q <= lo_d;
            end
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against a 64-bit arithmetic reference model.
module tb_mult_div_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, busy;
  logic [31:0] A = '0, B = '0, HI, LO;
  logic [2:0]  MDop = '0;
  int          nvec = 0, nerr = 0;
  logic [31:0] hi_m = '0, lo_m = '0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDop(MDop), .start(start),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: what an accepted op does to HI/LO, and how long busy lasts.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int len);
    longint sa, sb, ua, ub, p, q, r;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'b0, a};           ub = {32'b0, b};
    len = 0;
    case (op)
      3'd1: begin p = sa * sb; {hi_m, lo_m} = p; len = 5; end
      3'd2: begin p = ua * ub; {hi_m, lo_m} = p; len = 5; end
      3'd3: begin
        len = 10;
        if (b != 0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
      end
      3'd4: begin
        len = 10;
        if (b != 0) begin q = ua / ub; r = ua % ub; lo_m = q[31:0]; hi_m = r[31:0]; end
      end
      3'd5: hi_m = a;
      3'd6: lo_m = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    int len, cyc;
    @(negedge clk);
    MDop = op; A = a; B = b; start = 1'b1;
    model(op, a, b, len);
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; MDop = $urandom_range(0, 7);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      if (inject && cyc == 2) begin
        start = 1'b1; MDop = 3'd1; A = $urandom; B = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      A = $urandom; B = $urandom;
    end
    start = 1'b0;
    chk($sformatf("busy_len op%0d", op), 64'(cyc), 64'(len));
    chk($sformatf("HI op%0d", op), {32'b0, HI}, {32'b0, hi_m});
    chk($sformatf("LO op%0d", op), {32'b0, LO}, {32'b0, lo_m});
  endtask

  initial begin
    int cyc;
    logic [2:0] op;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_HI", {32'b0, HI}, 64'd0);
    chk("rst_LO", {32'b0, LO}, 64'd0);

    run_op(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
    chk("mult_HI_const", {32'b0, HI}, 64'hFFFFFFFF);
    chk("mult_LO_const", {32'b0, LO}, 64'hFFFFFFF1);
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("multu_HI_const", {32'b0, HI}, 64'h1);
    chk("multu_LO_const", {32'b0, LO}, 64'hFFFFFFFE);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_LO_const", {32'b0, LO}, 64'hFFFFFFFD);
    chk("div_HI_const", {32'b0, HI}, 64'hFFFFFFFF);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("divovf_LO_const", {32'b0, LO}, 64'h80000000);
    chk("divovf_HI_const", {32'b0, HI}, 64'h0);
    run_op(3'd5, 32'h1234, 32'd0, 1'b0);
    run_op(3'd6, 32'h5678, 32'd0, 1'b0);
    run_op(3'd4, 32'hDEADBEEF, 32'd0, 1'b0);
    chk("div0_HI_const", {32'b0, HI}, 64'h1234);
    chk("div0_LO_const", {32'b0, LO}, 64'h5678);
    run_op(3'd4, 32'd100, 32'd7, 1'b1);   // mult start during busy must be dropped
    run_op(3'd0, 32'hAAAA5555, 32'd3, 1'b0);
    run_op(3'd7, 32'hAAAA5555, 32'd3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(op, ra, rb, (i % 5) == 0);
    end

    // Reset on the third busy cycle of a div aborts it.
    @(negedge clk);
    MDop = 3'd3; A = 32'd1000; B = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_HI", {32'b0, HI}, 64'd0);
    chk("abort_LO", {32'b0, LO}, 64'd0);
    cyc = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy || HI != 0 || LO != 0) cyc++;
    end
    chk("abort_no_update", 64'(cyc), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
